// File: rtl/frame_streamer.sv
// frame_streamer: holds one NxN 8-bit frame and streams it to the kernel bank as a
// write sweep followed by a read sweep. Optional macro: FRAME_STREAMER_CONTINUOUS_EN.
module frame_streamer #(
   parameter int N           = 8,
   parameter int BIT_SIZE    = 6,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_we,
   input  logic [BIT_SIZE:0]   load_addr,
   input  logic [7:0]          load_data,
   input  logic                start,
   output logic                we,
   output logic [BIT_SIZE:0]   pixel_position_or_address,
   output logic [7:0]          data_out,
   output logic                sample_strobe,
   output logic                busy,
   output logic                done
);

   localparam int AW     = BIT_SIZE + 1;
   localparam int PIXELS = N * N;
   localparam int IW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam int HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   state_t          nxt_state;
   logic [HW-1:0]   hc;
   logic [HW-1:0]   nxt_hc;
   logic [AW-1:0]   nxt_addr;
   logic            nxt_we;
   logic [7:0]      nxt_data;
   logic            load_window;
   logic            load_ok;
   logic [7:0]      first_pixel;
   logic [7:0]      frame [PIXELS];

   // The frame only changes while no pass is running, so a sweep always sees a stable image.
`ifdef FRAME_STREAMER_CONTINUOUS_EN
   assign load_window = (state == IDLE) || (state == DONE);
`else
   assign load_window = (state == IDLE);
`endif

   assign load_ok     = load_we && load_window && (load_addr <= LAST_ADDR);
   assign first_pixel = (load_ok && (load_addr == '0)) ? load_data : frame[0];

   // Frame buffer has no reset: its contents survive rst.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         frame[IW'(load_addr)] <= load_data;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_hc    = hc;
      nxt_addr  = pixel_position_or_address;
      nxt_we    = we;
      nxt_data  = data_out;
      case (state)
         IDLE: begin
            nxt_hc   = '0;
            nxt_addr = '0;
            nxt_we   = 1'b0;
            nxt_data = '0;
            if (start) begin
               nxt_state = WRITE;
               nxt_we    = 1'b1;
               nxt_data  = first_pixel;
            end
         end
         WRITE: begin
            if (hc == HOLD_LAST) begin
               nxt_hc = '0;
               if (pixel_position_or_address == LAST_ADDR) begin
                  nxt_state = READ;
                  nxt_addr  = '0;
                  nxt_we    = 1'b0;
                  nxt_data  = '0;
               end else begin
                  nxt_addr = pixel_position_or_address + AW'(1);
                  nxt_data = frame[IW'(pixel_position_or_address + AW'(1))];
               end
            end else begin
               nxt_hc = hc + HW'(1);
            end
         end
         READ: begin
            if (hc == HOLD_LAST) begin
               nxt_hc = '0;
               if (pixel_position_or_address == LAST_ADDR) begin
                  nxt_state = DONE;
                  nxt_addr  = '0;
               end else begin
                  nxt_addr = pixel_position_or_address + AW'(1);
               end
            end else begin
               nxt_hc = hc + HW'(1);
            end
         end
         DONE: begin
            nxt_hc   = '0;
            nxt_addr = '0;
            nxt_we   = 1'b0;
            nxt_data = '0;
`ifdef FRAME_STREAMER_CONTINUOUS_EN
            nxt_state = WRITE;
            nxt_we    = 1'b1;
            nxt_data  = first_pixel;
`else
            nxt_state = IDLE;
`endif
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   // Strobe, busy and done are derived from the next state so every output is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                     <= IDLE;
         hc                        <= '0;
         pixel_position_or_address <= '0;
         we                        <= 1'b0;
         data_out                  <= '0;
         sample_strobe             <= 1'b0;
         busy                      <= 1'b0;
         done                      <= 1'b0;
      end else begin
         state                     <= nxt_state;
         hc                        <= nxt_hc;
         pixel_position_or_address <= nxt_addr;
         we                        <= nxt_we;
         data_out                  <= nxt_data;
         sample_strobe             <= (nxt_state == READ) && (nxt_hc == HOLD_LAST);
         busy                      <= (nxt_state == WRITE) || (nxt_state == READ);
         done                      <= (nxt_state == DONE);
      end
   end

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: scoreboard bench for frame_streamer (default single-pass build).
// Stimulus pushes the whole expected pass into a queue; a negedge monitor pops and compares.
module tb_frame_streamer;

   localparam int N      = 8;
   localparam int BS     = 6;
   localparam int HOLD   = 2;
   localparam int PIXELS = N * N;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_we = 1'b0;
   logic [BS:0]   load_addr = '0;
   logic [7:0]    load_data = '0;
   logic          start = 1'b0;
   logic          we;
   logic [BS:0]   pixel_position_or_address;
   logic [7:0]    data_out;
   logic          sample_strobe;
   logic          busy;
   logic          done;

   typedef struct packed {
      logic          we;
      logic [BS:0]   addr;
      logic [7:0]    data;
      logic          strobe;
      logic          busy;
      logic          done;
   } beat_t;

   beat_t       exp_q[$];
   logic [7:0]  model_frame [PIXELS];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          busy_run = 0;

   frame_streamer #(.N(N), .BIT_SIZE(BS), .HOLD_CYCLES(HOLD)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .load_we                   (load_we),
      .load_addr                 (load_addr),
      .load_data                 (load_data),
      .start                     (start),
      .we                        (we),
      .pixel_position_or_address (pixel_position_or_address),
      .data_out                  (data_out),
      .sample_strobe             (sample_strobe),
      .busy                      (busy),
      .done                      (done)
   );

   always #5 clk = ~clk;

   // Monitor: every active cycle must match the next expected beat; idle cycles must be all-zero.
   always @(negedge clk) begin
      beat_t act;
      beat_t exp_b;
      if (!rst) begin
         act = '{we: we, addr: pixel_position_or_address, data: data_out,
                 strobe: sample_strobe, busy: busy, done: done};
         n_cmp++;
         if (busy || done) begin
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected_output actual=%h required=<none> t=%0t", act, $time);
            end else begin
               exp_b = exp_q.pop_front();
               if (act !== exp_b) begin
                  n_fail++;
                  $display("[TB] FAIL beat actual we=%b addr=%0d data=%h strb=%b busy=%b done=%b required we=%b addr=%0d data=%h strb=%b busy=%b done=%b t=%0t",
                           act.we, act.addr, act.data, act.strobe, act.busy, act.done,
                           exp_b.we, exp_b.addr, exp_b.data, exp_b.strobe, exp_b.busy, exp_b.done, $time);
               end
            end
         end else if (act !== '0) begin
            n_fail++;
            $display("[TB] FAIL idle_outputs actual=%h required=0 t=%0t", act, $time);
         end
         if (busy) begin
            busy_run++;
         end else if (done) begin
            n_cmp++;
            if (busy_run != 2 * PIXELS * HOLD) begin
               n_fail++;
               $display("[TB] FAIL busy_length actual=%0d required=%0d", busy_run, 2 * PIXELS * HOLD);
            end
            busy_run = 0;
         end else begin
            busy_run = 0;
         end
      end
   end

   // Reference pass: every pixel held HOLD cycles while written, then a data-less read sweep.
   task automatic push_pass();
      for (int p = 0; p < PIXELS; p++)
         for (int h = 0; h < HOLD; h++)
            exp_q.push_back('{we: 1'b1, addr: (BS+1)'(p), data: model_frame[p],
                              strobe: 1'b0, busy: 1'b1, done: 1'b0});
      for (int p = 0; p < PIXELS; p++)
         for (int h = 0; h < HOLD; h++)
            exp_q.push_back('{we: 1'b0, addr: (BS+1)'(p), data: 8'h00,
                              strobe: (h == HOLD - 1), busy: 1'b1, done: 1'b0});
      exp_q.push_back('{we: 1'b0, addr: '0, data: 8'h00, strobe: 1'b0, busy: 1'b0, done: 1'b1});
   endtask

   task automatic load_pixel(input int addr, input logic [7:0] data);
      load_we   = 1'b1;
      load_addr = (BS+1)'(addr);
      load_data = data;
      if (addr < PIXELS) model_frame[addr] = data;
      @(posedge clk); #1;
      load_we = 1'b0;
   endtask

   task automatic apply_stimulus(input logic collide, input logic [7:0] coll_data);
      start = 1'b1;
      if (collide) begin
         load_we   = 1'b1;
         load_addr = '0;
         load_data = coll_data;
         model_frame[0] = coll_data;
      end
      push_pass();
      @(posedge clk); #1;
      start   = 1'b0;
      load_we = 1'b0;
   endtask

   task automatic wait_pass();
      int cyc;
      cyc = 0;
      while ((exp_q.size() != 0 || busy || done) && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if (cyc >= 1000) begin
         n_fail++;
         $display("[TB] FAIL pass_timeout actual=%0d pending required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_output(input string name, input int actual, input int required);
      n_cmp++;
      if (actual != required) begin
         n_fail++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_we"}, int'(we), 0);
      check_output({tag, "_addr"}, int'(pixel_position_or_address), 0);
      check_output({tag, "_data"}, int'(data_out), 0);
      check_output({tag, "_strobe"}, int'(sample_strobe), 0);
      check_output({tag, "_busy"}, int'(busy), 0);
      check_output({tag, "_done"}, int'(done), 0);
   endtask

   initial begin
      for (int i = 0; i < PIXELS; i++) model_frame[i] = 8'h00;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Basic pass with frame[i] = i.
      for (int i = 0; i < PIXELS; i++) load_pixel(i, 8'(i));
      apply_stimulus(1'b0, 8'h00);
      wait_pass();

      // Start and load pulsed mid-WRITE, before pixel 5 is streamed: both must be ignored.
      apply_stimulus(1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; load_we = 1'b1; load_addr = 7'd5; load_data = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0; load_we = 1'b0;
      wait_pass();

      // Random frame, including out-of-range addresses that must be dropped.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 40; i++)
            load_pixel(int'($urandom_range(0, 2 ** (BS + 1) - 1)), 8'($urandom));
         apply_stimulus(1'b0, 8'h00);
         wait_pass();
      end

      // Load/start collision: the freshly loaded pixel 0 is streamed first.
      apply_stimulus(1'b1, 8'hAA);
      wait_pass();

      // Mid-pass reset, then a fresh pass from the intact buffer.
      apply_stimulus(1'b0, 8'h00);
      repeat (39) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      check_reset_outputs("midreset");
      apply_stimulus(1'b0, 8'h00);
      wait_pass();

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
